aes_ctr_ctrl: RTL and testbench
===============================

// Module: aes_ctr_ctrl
// PURPOSE
// CTR-mode sequencer that sits directly upstream of aes_core and also consumes its results.
// It loads the key into the core and feeds counter blocks to the core (encdec=1 always).
// It XORs each keystream result with the incoming data block and emits the result on a
// valid/ready stream. It turns the block-level core into a streaming 128-bit CTR cipher.
// PARAMETERS
// CTR_WIDTH  32  low IV bits incremented per block (1..128); upper 128-CTR_WIDTH bits are fixed nonce
// PORTS
// clk          in   1    clock; single clock domain
// reset        in   1    synchronous, active-high reset
// key_load     in   1    pulse: latch key/keylen and run core key expansion
// key          in   256  cipher key, sampled when key_load is accepted
// keylen       in   1    0=AES-128, 1=AES-256; passed to core
// iv_load      in   1    pulse: latch iv as the counter and clear ctr_wrap
// iv           in   128  initial counter block
// busy         out  1    high when any state other than IDLE/WAIT_DATA is active
// in_valid     in   1    input data block valid
// in_ready     out  1    input data block accepted this cycle when in_valid & in_ready
// in_data      in   128  plaintext or ciphertext block
// out_valid    out  1    output block valid; held until out_ready
// out_ready    in   1    downstream accepts output
// out_data     out  128  in_data XOR AES_K(counter)
// ctr_wrap     out  1    sticky: counter field wrapped from all-ones to 0
// core_init    out  1    to aes_core init (single-cycle pulse)
// core_next    out  1    to aes_core next (single-cycle pulse)
// core_encdec  out  1    tied 1
// core_key     out  256  registered key
// core_keylen  out  1    registered keylen
// core_block   out  128  registered counter; stable from core_next until result is captured
// core_ready   in   1    from aes_core ready
// core_result  in   128  from aes_core result
// core_result_valid in 1 from aes_core result_valid
// BEHAVIOUR
// Reset: state=RESYNC. in_ready, out_valid, core_init, core_next, ctr_wrap and key_valid are 0.
//   core_block, core_key, core_keylen and out_data are 0. busy=1.
// FSM: RESYNC -> IDLE once core_ready=1. This covers a reset mid-operation while the core is still busy.
// IDLE/WAIT_DATA: accepts key_load and iv_load (busy=0). If key_load and iv_load arrive
//   in the same cycle, both are latched.
//   After key_load, go to KEY_START. If key_valid=1, WAIT_DATA is used instead of IDLE.
// KEY_START: core_init=1 for exactly one cycle -> KEY_WAIT.
// KEY_WAIT: core_ready=1 -> set key_valid, go to WAIT_DATA. (The core drops ready on the edge after init.)
// WAIT_DATA: in_ready=1 iff key_valid & !key_load & !iv_load. On accept, latch in_data -> NEXT_START.
// NEXT_START: core_next=1 for one cycle -> CORE_WAIT.
// CORE_WAIT: core_ready & core_result_valid -> out_data <= core_result ^ data_reg; out_valid=1.
//   Also increment the counter -> OUT_HOLD.
// OUT_HOLD: hold out_valid/out_data until out_ready. On the handshake, out_valid=0 -> WAIT_DATA.
// Latency: accept at edge N; core_next high in cycle N+1. out_valid rises 1 cycle after
//   core_result_valid rises. Minimum input-accept spacing = core latency + 3 cycles.
// Counter: ctr[CTR_WIDTH-1:0] += 1 mod 2^CTR_WIDTH; upper bits are never modified.
//   All-ones -> 0 sets ctr_wrap. The block keeps running; ctr_wrap clears only on iv_load or reset.
// key_load/iv_load outside IDLE/WAIT_DATA are ignored (not queued).
// key_valid is cleared by reset only; a new key_load re-expands the key and keeps key_valid=1 after KEY_WAIT.
// core_init and core_next are never high in the same cycle, and never issued while core_ready=0.
// TESTING
// 1 Reset with core_ready=0 for 5 cycles -> busy=1, in_ready=0; IDLE reached the cycle after core_ready=1.
// 2 key_load K=2b7e151628aed2a6abf7158809cf4f3c (keylen=0), iv=f0f1..feff, in=6bc1bee22e409f96e93d7e117393172a
//   -> out_data=874d6191b620e3261bef6864990db6ce; core_block then reads ...fcfdff00.
// 3 Hold out_ready=0 for 10 cycles -> out_valid/out_data stable, in_ready=0; release -> one transfer only.
// 4 CTR_WIDTH=32, iv=...ffffffff, two blocks -> second core_block=...00000000 (upper 96 unchanged), ctr_wrap=1;
//   a subsequent iv_load clears it.
// 5 Assert reset during CORE_WAIT -> out_valid=0 next cycle; no core_next until core_ready=1 and a key is reloaded.
// 6 key_load and iv_load in the same cycle while in WAIT_DATA -> both latched; single core_init pulse; in_ready=0 that cycle.

Source files
------------

// File: rtl/aes_ctr_ctrl_if.sv
// Bundles the streaming data path, the key/IV load controls and the aes_core side-band
// of the CTR sequencer into one interface.
//   slave  : seen from aes_ctr_ctrl (loads/data/core results in, stream/core controls out)
//   master : seen from the surrounding logic (host side plus aes_core)
// Signals:
//   key_load/key/keylen      key latch request and payload
//   iv_load/iv               counter block load request and payload
//   busy                     sequencer is neither idle nor waiting for data
//   in_valid/in_ready/in_data     input block stream
//   out_valid/out_ready/out_data  output block stream
//   ctr_wrap                 sticky counter-field wrap flag
//   core_*                   connection to aes_core
interface aes_ctr_ctrl_if;
  localparam int unsigned BLK_W = 128;
  localparam int unsigned KEY_W = 256;

  logic             key_load;
  logic [KEY_W-1:0] key;
  logic             keylen;
  logic             iv_load;
  logic [BLK_W-1:0] iv;
  logic             busy;
  logic             in_valid;
  logic             in_ready;
  logic [BLK_W-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [BLK_W-1:0] out_data;
  logic             ctr_wrap;
  logic             core_init;
  logic             core_next;
  logic             core_encdec;
  logic [KEY_W-1:0] core_key;
  logic             core_keylen;
  logic [BLK_W-1:0] core_block;
  logic             core_ready;
  logic [BLK_W-1:0] core_result;
  logic             core_result_valid;

  modport slave (
    input  key_load, key, keylen, iv_load, iv,
    input  in_valid, in_data, out_ready,
    input  core_ready, core_result, core_result_valid,
    output busy, in_ready, out_valid, out_data, ctr_wrap,
    output core_init, core_next, core_encdec, core_key, core_keylen, core_block
  );

  modport master (
    output key_load, key, keylen, iv_load, iv,
    output in_valid, in_data, out_ready,
    output core_ready, core_result, core_result_valid,
    input  busy, in_ready, out_valid, out_data, ctr_wrap,
    input  core_init, core_next, core_encdec, core_key, core_keylen, core_block
  );
endinterface

// File: rtl/aes_ctr_ctrl.sv
// CTR-mode sequencer wrapped around aes_core: expands the key, feeds counter blocks to the
// core, XORs each keystream block with an input block and emits the result on a
// valid/ready stream.
// Ports:
//   clk    clock
//   reset  synchronous, active-high reset
//   bus    aes_ctr_ctrl_if.slave (load controls, in/out streams, aes_core connection)
// in_ready is the only combinational output; everything else is registered.
module aes_ctr_ctrl #(
  parameter int unsigned CTR_WIDTH = 32
) (
  input  logic          clk,
  input  logic          reset,
  aes_ctr_ctrl_if.slave bus
);

  localparam int unsigned BLK_W = 128;
  localparam int unsigned KEY_W = 256;

  typedef enum logic [2:0] {
    ST_RESYNC,
    ST_IDLE,
    ST_KEY_START,
    ST_KEY_WAIT,
    ST_WAIT_DATA,
    ST_NEXT_START,
    ST_CORE_WAIT,
    ST_OUT_HOLD
  } state_e;

  state_e               state_q, state_d;
  logic                 key_valid_q, key_valid_d;
  logic [KEY_W-1:0]     key_q, key_d;
  logic                 keylen_q, keylen_d;
  logic [BLK_W-1:0]     ctr_q, ctr_d, ctr_inc;
  logic [CTR_WIDTH-1:0] ctr_lo;
  logic                 wrap_q, wrap_d;
  logic [BLK_W-1:0]     data_q, data_d;
  logic [BLK_W-1:0]     out_data_q, out_data_d;
  logic                 out_valid_q, out_valid_d;
  logic                 init_q, init_d;
  logic                 next_q, next_d;
  logic                 busy_q, busy_d;
  logic                 in_ready_c;
  logic                 accept_c;

  // Only the low CTR_WIDTH bits count; the nonce above them is carried through untouched.
  assign ctr_lo = ctr_q[CTR_WIDTH-1:0];

  always_comb begin
    ctr_inc                = ctr_q;
    ctr_inc[CTR_WIDTH-1:0] = ctr_lo + CTR_WIDTH'(1);
  end

  // A load request in the same cycle takes priority over data acceptance.
  assign in_ready_c = (state_q == ST_WAIT_DATA) & key_valid_q & ~bus.key_load & ~bus.iv_load;
  assign accept_c   = in_ready_c & bus.in_valid;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_RESYNC;
      key_valid_q <= 1'b0;
      key_q       <= '0;
      keylen_q    <= 1'b0;
      ctr_q       <= '0;
      wrap_q      <= 1'b0;
      data_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      init_q      <= 1'b0;
      next_q      <= 1'b0;
      busy_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      key_valid_q <= key_valid_d;
      key_q       <= key_d;
      keylen_q    <= keylen_d;
      ctr_q       <= ctr_d;
      wrap_q      <= wrap_d;
      data_q      <= data_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      init_q      <= init_d;
      next_q      <= next_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state and datapath updates
  always_comb begin
    state_d     = state_q;
    key_valid_d = key_valid_q;
    key_d       = key_q;
    keylen_d    = keylen_q;
    ctr_d       = ctr_q;
    wrap_d      = wrap_q;
    data_d      = data_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;

    unique case (state_q)
      // Wait out any operation the core was running when reset hit.
      ST_RESYNC: begin
        if (bus.core_ready) begin
          state_d = key_valid_q ? ST_WAIT_DATA : ST_IDLE;
        end
      end
      ST_IDLE, ST_WAIT_DATA: begin
        if (bus.iv_load) begin
          ctr_d  = bus.iv;
          wrap_d = 1'b0;
        end
        if (bus.key_load) begin
          key_d    = bus.key;
          keylen_d = bus.keylen;
          state_d  = ST_KEY_START;
        end else if (accept_c) begin
          data_d  = bus.in_data;
          state_d = ST_NEXT_START;
        end
      end
      ST_KEY_START: begin
        state_d = ST_KEY_WAIT;
      end
      // Core drops ready on the edge after init, so ready here means expansion is done.
      ST_KEY_WAIT: begin
        if (bus.core_ready) begin
          key_valid_d = 1'b1;
          state_d     = ST_WAIT_DATA;
        end
      end
      ST_NEXT_START: begin
        state_d = ST_CORE_WAIT;
      end
      ST_CORE_WAIT: begin
        if (bus.core_ready & bus.core_result_valid) begin
          out_data_d  = bus.core_result ^ data_q;
          out_valid_d = 1'b1;
          ctr_d       = ctr_inc;
          if (&ctr_lo) begin
            wrap_d = 1'b1;
          end
          state_d = ST_OUT_HOLD;
        end
      end
      ST_OUT_HOLD: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_WAIT_DATA;
        end
      end
      default: begin
        state_d = ST_RESYNC;
      end
    endcase
  end

  // Core strobes and busy follow the state being entered so they line up with it.
  assign init_d = (state_d == ST_KEY_START);
  assign next_d = (state_d == ST_NEXT_START);
  assign busy_d = ~((state_d == ST_IDLE) | (state_d == ST_WAIT_DATA));

  assign bus.busy        = busy_q;
  assign bus.in_ready    = in_ready_c;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_data    = out_data_q;
  assign bus.ctr_wrap    = wrap_q;
  assign bus.core_init   = init_q;
  assign bus.core_next   = next_q;
  assign bus.core_encdec = 1'b1;
  assign bus.core_key    = key_q;
  assign bus.core_keylen = keylen_q;
  assign bus.core_block  = ctr_q;

endmodule

// File: tb/tb_aes_ctr_ctrl.sv
// Bench for aes_ctr_ctrl: a behavioural aes_core stand-in (full AES-128/256 encryption,
// programmable latency) plus a CTR reference model that predicts every output block.
module tb_aes_ctr_ctrl;
  localparam int unsigned CW = 32;
  localparam logic [127:0] LO_MASK = {{(128-CW){1'b0}}, {CW{1'b1}}};

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  aes_ctr_ctrl_if cif();
  aes_ctr_ctrl #(.CTR_WIDTH(CW)) dut (.clk(clk), .reset(reset), .bus(cif));

  int n_chk = 0;
  int n_pass = 0;
  int n_init = 0;
  int n_next = 0;
  int n_xfer = 0;

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // ---------------- AES reference ----------------
  logic [7:0] sbox_t [256];

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, b;
    for (int v = 0; v < 256; v++) begin
      inv = 8'h01;
      for (int e = 0; e < 254; e++) inv = gmul(inv, 8'(v));
      b = inv;
      sbox_t[v] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
  endfunction

  // AES-128 uses key[255:128]; AES-256 uses the whole key.
  function automatic logic [127:0] aes_enc(input logic [255:0] k, input logic klen, input logic [127:0] pt);
    logic [31:0]  w [60];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [31:0]  tmp;
    logic [7:0]   rc, a0, a1, a2, a3;
    logic [127:0] ct;
    int nk, nr;
    nk = klen ? 8 : 4;
    nr = nk + 6;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = k[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      tmp = w[i-1];
      if (i % nk == 0) begin
        tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
        rc  = xtime(rc);
      end else if (nk == 8 && i % nk == 4) begin
        tmp = subw(tmp);
      end
      w[i] = w[i-nk] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int r = 1; r <= nr; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sbox_t[s[(((i/4) + (i%4)) % 4)*4 + (i%4)]];
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        if (r < nr) begin
          s[4*c]   = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
          s[4*c+1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
          s[4*c+2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
          s[4*c+3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end else begin
          s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*r + i/4][31-8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) ct[127-8*i -: 8] = s[i];
    return ct;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- aes_core stand-in ----------------
  logic         cm_busy = 1'b0;
  logic         cm_stall = 1'b1;
  logic         cm_op_next = 1'b0;
  int           cm_cnt = 0;
  int           cm_lat = 2;
  logic [255:0] cm_key = '0;
  logic         cm_klen = 1'b0;
  logic [127:0] cm_blk = '0;
  logic         cm_rv = 1'b0;
  logic [127:0] cm_res = '0;

  assign cif.core_ready        = ~cm_busy & ~cm_stall;
  assign cif.core_result_valid = cm_rv;
  assign cif.core_result       = cm_res;

  always @(posedge clk) begin
    if (cif.core_init || cif.core_next) begin
      check_eq("issue_ready", cif.core_ready, 1'b1);
      check_eq("init_next_excl", cif.core_init & cif.core_next, 1'b0);
      check_eq("encdec", cif.core_encdec, 1'b1);
    end
    if (cm_busy) begin
      if (cm_cnt == 0) begin
        cm_busy <= 1'b0;
        if (cm_op_next) begin
          cm_res <= aes_enc(cm_key, cm_klen, cm_blk);
          cm_rv  <= 1'b1;
        end
      end else begin
        cm_cnt <= cm_cnt - 1;
      end
    end else if (cif.core_ready && (cif.core_init || cif.core_next)) begin
      cm_busy    <= 1'b1;
      cm_cnt     <= cm_lat;
      cm_rv      <= 1'b0;
      cm_op_next <= cif.core_next;
      if (cif.core_init) begin
        cm_key  <= cif.core_key;
        cm_klen <= cif.core_keylen;
      end else begin
        cm_blk <= cif.core_block;
      end
    end
  end

  always @(posedge clk) begin
    if (cif.core_init) n_init <= n_init + 1;
    if (cif.core_next) n_next <= n_next + 1;
    if (cif.out_valid && cif.out_ready) n_xfer <= n_xfer + 1;
  end

  // ---------------- CTR reference model ----------------
  logic [255:0] m_key;
  logic         m_klen;
  logic [127:0] m_ctr;
  logic         m_wrap;

  function automatic logic [127:0] model_block(input logic [127:0] d);
    logic [127:0] ks;
    ks = aes_enc(m_key, m_klen, m_ctr);
    if ((m_ctr & LO_MASK) == LO_MASK) m_wrap = 1'b1;
    m_ctr = (m_ctr & ~LO_MASK) | ((m_ctr + 128'd1) & LO_MASK);
    return d ^ ks;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    int i;
    i = 0;
    while (cif.busy && i < 300) begin
      step();
      i++;
    end
    check_eq({tag, "_idle"}, cif.busy, 1'b0);
  endtask

  task automatic do_reset(input int stall);
    int i, rdy_at, n0;
    logic bad;
    reset = 1'b1;
    cif.key_load = 1'b0;
    cif.iv_load = 1'b0;
    cif.out_ready = 1'b0;
    cif.in_valid = 1'b1;
    cif.in_data = rnd128();
    if (stall > 0) cm_stall = 1'b1;
    step();
    check_eq("rst_ctl", {cif.busy, cif.in_ready, cif.out_valid, cif.core_init, cif.core_next,
                         cif.ctr_wrap, cif.core_keylen}, 7'b1000000);
    check_eq("rst_block", cif.core_block, 128'h0);
    check_eq("rst_key", cif.core_key, 256'h0);
    check_eq("rst_out_data", cif.out_data, 128'h0);
    reset = 1'b0;
    n0 = n_next;
    m_key = '0; m_klen = 1'b0; m_ctr = '0; m_wrap = 1'b0;
    bad = 1'b0;
    repeat (stall) begin
      step();
      if (!cif.busy || cif.in_ready) bad = 1'b1;
    end
    if (stall > 0) check_eq("rst_stall_busy", bad, 1'b0);
    cm_stall = 1'b0;
    #1;
    i = 0;
    rdy_at = -100;
    while (cif.busy && i < 300) begin
      if (cif.core_ready && rdy_at < 0) rdy_at = i;
      if (cif.in_ready) bad = 1'b1;
      step();
      i++;
    end
    check_eq("resync_exit", 32'(i - rdy_at), 32'd1);
    repeat (5) begin
      if (cif.in_ready) bad = 1'b1;
      step();
    end
    check_eq("idle_no_accept", bad, 1'b0);
    check_eq("idle_no_next", 32'(n_next - n0), 32'd0);
    check_eq("idle_out_valid", cif.out_valid, 1'b0);
    cif.in_valid = 1'b0;
  endtask

  task automatic load(input bit do_key, input bit do_iv, input logic [255:0] k,
                      input logic klen, input logic [127:0] v);
    int n0;
    wait_idle("load");
    n0 = n_init;
    cif.key_load = do_key;
    cif.iv_load = do_iv;
    cif.key = k;
    cif.keylen = klen;
    cif.iv = v;
    cif.in_valid = 1'b1;
    cif.in_data = rnd128();
    #1;
    check_eq("load_in_ready", cif.in_ready, 1'b0);
    step();
    cif.key_load = 1'b0;
    cif.iv_load = 1'b0;
    cif.in_valid = 1'b0;
    if (do_iv) begin
      m_ctr = v;
      m_wrap = 1'b0;
      check_eq("iv_block", cif.core_block, v);
      check_eq("iv_wrap", cif.ctr_wrap, 1'b0);
    end
    if (do_key) begin
      m_key = k;
      m_klen = klen;
      wait_idle("key");
      check_eq("init_pulses", 32'(n_init - n0), 32'd1);
      check_eq("key_reg", cif.core_key, k);
      check_eq("keylen_reg", cif.core_keylen, klen);
    end
  endtask

  task automatic send(input logic [127:0] d, input int hold, output logic [127:0] got);
    logic [127:0] exp;
    int i, rv_cyc, ni0, nx0;
    logic stable;
    ni0 = n_init;
    nx0 = n_xfer;
    cif.in_valid = 1'b1;
    cif.in_data = d;
    #1;
    i = 0;
    while (!cif.in_ready && i < 300) begin
      step();
      i++;
    end
    check_eq("send_in_ready", cif.in_ready, 1'b1);
    exp = model_block(d);
    step();
    cif.in_valid = 1'b0;
    check_eq("next_pulse", cif.core_next, 1'b1);
    step();
    i = 0;
    rv_cyc = -100;
    while (!cif.out_valid && i < 300) begin
      if (cif.core_result_valid && rv_cyc < 0) rv_cyc = i;
      step();
      i++;
    end
    check_eq("out_latency", 32'(i - rv_cyc), 32'd1);
    check_eq("out_data", cif.out_data, exp);
    got = cif.out_data;
    stable = 1'b1;
    // Load requests while the output is held must be ignored.
    cif.key_load = (hold > 0);
    cif.iv_load = (hold > 0);
    cif.key = ~m_key;
    cif.iv = ~m_ctr;
    repeat (hold) begin
      step();
      if (!cif.out_valid || cif.out_data !== exp || cif.in_ready) stable = 1'b0;
    end
    if (hold > 0) check_eq("hold_stable", stable, 1'b1);
    cif.key_load = 1'b0;
    cif.iv_load = 1'b0;
    cif.out_ready = 1'b1;
    step();
    cif.out_ready = 1'b0;
    check_eq("out_drop", cif.out_valid, 1'b0);
    check_eq("one_xfer", 32'(n_xfer - nx0), 32'd1);
    check_eq("ctr", cif.core_block, m_ctr);
    check_eq("wrap", cif.ctr_wrap, m_wrap);
    check_eq("no_stray_init", 32'(n_init - ni0), 32'd0);
    check_eq("key_kept", cif.core_key, m_key);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [127:0] got, up;
    int r;
    build_sbox();
    reset = 1'b1;
    cif.key_load = 1'b0; cif.key = '0; cif.keylen = 1'b0;
    cif.iv_load = 1'b0; cif.iv = '0;
    cif.in_valid = 1'b0; cif.in_data = '0; cif.out_ready = 1'b0;

    // Reset with the core not ready
    do_reset(5);

    // NIST CTR-AES128 vectors, second block held for 10 cycles
    cm_lat = 3;
    load(1, 1, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 1'b0,
         128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff);
    send(128'h6bc1bee22e409f96e93d7e117393172a, 0, got);
    check_eq("kat_blk1", got, 128'h874d6191b620e3261bef6864990db6ce);
    check_eq("kat_ctr1", cif.core_block, 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdff00);
    send(128'hae2d8a571e03ac9c9eb76fac45af8e51, 10, got);
    check_eq("kat_blk2", got, 128'h9806f66b7970fdff8617187bb9fffdff);

    // Counter field wrap
    up = rnd128();
    load(0, 1, '0, 1'b0, {up[127:32], 32'hffffffff});
    send(rnd128(), 0, got);
    check_eq("wrap_block", cif.core_block, {up[127:32], 32'h0});
    check_eq("wrap_flag", cif.ctr_wrap, 1'b1);
    send(rnd128(), 1, got);
    check_eq("wrap_sticky", cif.ctr_wrap, 1'b1);
    load(0, 1, '0, 1'b0, rnd128() & ~LO_MASK);

    // Key and IV in the same cycle from WAIT_DATA; AES-256 known answer
    load(1, 1, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 1'b1,
         128'h00112233445566778899aabbccddeeff);
    send(128'h0, 2, got);
    check_eq("kat_aes256", got, 128'h8ea2b7ca516745bfeafc49904b496089);

    // Randomised traffic
    for (int it = 0; it < 24; it++) begin
      r = $urandom_range(0, 9);
      cm_lat = $urandom_range(0, 5);
      if (r < 7) begin
        send(rnd128(), $urandom_range(0, 3), got);
      end else if (r < 9) begin
        up = rnd128();
        if (r == 8) up[31:0] = 32'hffffffff - 32'($urandom_range(0, 2));
        load(0, 1, '0, 1'b0, up);
      end else begin
        load(1, 1'($urandom_range(0, 1)), {rnd128(), rnd128()}, 1'($urandom_range(0, 1)), rnd128());
      end
    end

    // Reset while the core is computing a block
    cm_lat = 8;
    cif.in_valid = 1'b1;
    cif.in_data = rnd128();
    #1;
    check_eq("t5_in_ready", cif.in_ready, 1'b1);
    step();
    cif.in_valid = 1'b0;
    step();
    step();
    check_eq("t5_busy", cif.busy, 1'b1);
    do_reset(0);
    cm_lat = 1;
    load(1, 1, {rnd128(), rnd128()}, 1'b0, rnd128());
    send(rnd128(), 1, got);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
